// File: rtl/struct_array_pkg.sv
// Shared types and helpers for the struct/array FIFO.
//   packed_struct_t : one struct lane, part_a in [5:2], part_b in [1:0]
//   STRUCT_W        : bit width of one struct lane
//   ENTRY_MAX_W     : widest entry entry_parity accepts (callers zero-extend)
//   entry_parity    : even-parity bit over an entry (zero padding is neutral)
// The lane-vector type struct_lanes_t depends on LANES, so each using module
// declares it locally as packed_struct_t [LANES-1:0].
package struct_array_pkg;

    localparam int STRUCT_W    = 6;
    localparam int ENTRY_MAX_W = 4096;

    typedef struct packed {
        logic [3:0] part_a;
        logic [1:0] part_b;
    } packed_struct_t;

    function automatic logic entry_parity(input logic [ENTRY_MAX_W-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/struct_array_fifo_mem.sv
// Flop-based storage for struct_array_fifo.
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (asynchronous read)
// The storage is not reset. The FIFO only reads slots that have already been written.
module struct_array_fifo_mem #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/struct_array_fifo.sv
// Multi-lane FIFO carrying packed_struct_t lanes plus a packed 2-D array.
// Uses a valid/ready handshake on both sides. There is no fall-through, and
// in_ready and out_valid depend only on registered state.
// Optional feature: define STRUCT_ARRAY_FIFO_PARITY_EN to store an even-parity
// bit per entry and to flag a sticky parity_err when a popped entry mismatches.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   producer handshake
//   in_struct, in_arr     entry written on push
//   out_valid / out_ready consumer handshake
//   out_struct, out_arr   head entry (mem[rd_ptr])
//   count                 occupied entries
//   parity_err            sticky parity error (0 when the parity feature is off)
module struct_array_fifo
    import struct_array_pkg::*;
#(
    parameter int LANES = 2,
    parameter int ARR_N = 2,
    parameter int ARR_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  packed_struct_t [LANES-1:0]     in_struct,
    input  logic [ARR_N-1:0][ARR_W-1:0]    in_arr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output packed_struct_t [LANES-1:0]     out_struct,
    output logic [ARR_N-1:0][ARR_W-1:0]    out_arr,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           parity_err
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int DATA_W = LANES * STRUCT_W + ARR_N * ARR_W;
`ifdef STRUCT_ARRAY_FIFO_PARITY_EN
    localparam int MEM_W  = DATA_W + 1;
`else
    localparam int MEM_W  = DATA_W;
`endif
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef packed_struct_t [LANES-1:0] struct_lanes_t;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              push, pop;
    logic [DATA_W-1:0] wdata_data;
    logic [MEM_W-1:0]  wdata;
    logic [MEM_W-1:0]  rdata;
    struct_lanes_t     head_struct;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wdata_data = {in_struct, in_arr};

`ifdef STRUCT_ARRAY_FIFO_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic head_mismatch;

    // The parity bit sits in the MSB, above the data bits.
    assign wdata         = {entry_parity(ENTRY_MAX_W'(wdata_data)), wdata_data};
    assign head_mismatch = entry_parity(ENTRY_MAX_W'(rdata[DATA_W-1:0])) != rdata[DATA_W];
    assign parity_err_d  = parity_err_q | (pop & head_mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign wdata      = wdata_data;
    assign parity_err = 1'b0;
`endif

    struct_array_fifo_mem #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign {head_struct, out_arr} = rdata[DATA_W-1:0];
    assign out_struct             = head_struct;

endmodule

// File: tb/tb_struct_array_fifo.sv
module tb_struct_array_fifo;
    import struct_array_pkg::*;

    typedef logic [19:0] entry_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    packed_struct_t [1:0]  in_struct;
    logic [1:0][3:0]       in_arr;
    logic                  out_valid;
    logic                  out_ready;
    packed_struct_t [1:0]  out_struct;
    logic [1:0][3:0]       out_arr;
    logic [2:0]            count;
    logic                  parity_err;

    int     checks   = 0;
    int     failures = 0;
    entry_t q[$];

    struct_array_fifo #(
        .LANES (2),
        .ARR_N (2),
        .ARR_W (4),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_struct  (in_struct),
        .in_arr     (in_arr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_struct (out_struct),
        .out_arr    (out_arr),
        .count      (count),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input entry_t e);
        {in_struct, in_arr} = e;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        q.delete();
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive('0);
        rst_n = 1'b0;
        #2;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL idle_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL idle_parity_err got=%b exp=0", parity_err); end
    endtask

    task automatic test_single();
        in_struct[0].part_a = 4'hA;
        in_struct[0].part_b = 2'h1;
        in_struct[1].part_a = 4'h3;
        in_struct[1].part_b = 2'h2;
        in_arr[1] = 4'h5;
        in_arr[0] = 4'hC;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        checks++; if (out_struct[0].part_a !== 4'hA) begin failures++; $display("FAIL single_l0_a got=%h exp=a", out_struct[0].part_a); end
        checks++; if (out_struct[0].part_b !== 2'h1) begin failures++; $display("FAIL single_l0_b got=%h exp=1", out_struct[0].part_b); end
        checks++; if (out_struct[1].part_a !== 4'h3) begin failures++; $display("FAIL single_l1_a got=%h exp=3", out_struct[1].part_a); end
        checks++; if (out_struct[1].part_b !== 2'h2) begin failures++; $display("FAIL single_l1_b got=%h exp=2", out_struct[1].part_b); end
        checks++; if (out_arr !== 8'h5C) begin failures++; $display("FAIL single_arr got=%h exp=5c", out_arr); end
        checks++; if ({out_struct, out_arr} !== 20'h3A95C) begin failures++; $display("FAIL single_raw got=%h exp=3a95c", {out_struct, out_arr}); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", out_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    endtask

    task automatic test_full();
        entry_t e [5] = '{20'hA1234, 20'h5B6C7, 20'hFEDCB, 20'h01089, 20'h77777};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(e[i]);
            in_valid = 1'b1;
            step();
            checks++; if (count !== 3'(i + 1)) begin failures++; $display("FAIL full_fill_count got=%0d exp=%0d", count, i + 1); end
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        checks++; if ({out_struct, out_arr} !== e[0]) begin failures++; $display("FAIL full_head0 got=%h exp=%h", {out_struct, out_arr}, e[0]); end
        drive(e[4]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_popnopush_count got=%0d exp=3", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_popnopush_ready got=%b exp=1", in_ready); end
        for (int k = 1; k < 4; k++) begin
            checks++; if ({out_struct, out_arr} !== e[k]) begin failures++; $display("FAIL full_drain_head got=%h exp=%h", {out_struct, out_arr}, e[k]); end
            step();
            checks++; if (count !== 3'(3 - k)) begin failures++; $display("FAIL full_drain_count got=%0d exp=%0d", count, 3 - k); end
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_drain_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        entry_t b [4] = '{20'h13579, 20'h2468A, 20'hC0FFE, 20'h0BEEF};
        drive(b[0]);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            drive(b[i]);
            step();
            checks++; if (count !== 3'd1) begin failures++; $display("FAIL b2b_count got=%0d exp=1", count); end
            checks++; if ({out_struct, out_arr} !== b[i]) begin failures++; $display("FAIL b2b_head got=%h exp=%h", {out_struct, out_arr}, b[i]); end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        bit     iv, ordy, push, pop;
        entry_t e;
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (((cyc / 500) % 2) == 0) begin
                iv   = ($urandom % 4) != 0;
                ordy = ($urandom % 2) != 0;
            end else begin
                iv   = ($urandom % 2) != 0;
                ordy = ($urandom % 4) != 0;
            end
            e = entry_t'($urandom);
            drive(e);
            in_valid  = iv;
            out_ready = ordy;
            push = iv && (q.size() != 4);
            pop  = ordy && (q.size() != 0);
            step();
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            checks++; if (count !== 3'(q.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, q.size()); end
            checks++; if (out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b", cyc, out_valid); end
            checks++; if (in_ready !== (q.size() != 4)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b", cyc, in_ready); end
            if (q.size() != 0) begin
                checks++; if ({out_struct, out_arr} !== q[0]) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", cyc, {out_struct, out_arr}, q[0]); end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        q.delete();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rnd_drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid();
        entry_t r [4] = '{20'h11111, 20'h22222, 20'h33333, 20'hABCDE};
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(r[i]);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=3", count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_rel_valid got=%b exp=0", out_valid); end
        drive(r[3]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL rstmid_push_count got=%0d exp=1", count); end
        checks++; if ({out_struct, out_arr} !== r[3]) begin failures++; $display("FAIL rstmid_head got=%h exp=%h", {out_struct, out_arr}, r[3]); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_alone got=%b exp=0", out_valid); end
    endtask

    task automatic test_parity();
        do_reset();
        drive(20'h6D2A1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_pre got=%b exp=0", parity_err); end
`ifdef STRUCT_ARRAY_FIFO_PARITY_EN
        dut.u_mem.mem_q[dut.rd_ptr_q][0] = ~dut.u_mem.mem_q[dut.rd_ptr_q][0];
        #1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_set got=%b exp=1", parity_err); end
        step();
        step();
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_sticky got=%b exp=1", parity_err); end
        do_reset();
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_rst got=%b exp=0", parity_err); end
`else
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_off got=%b exp=0", parity_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
